// File: rtl/hsst_tx_framer.sv
// hsst_tx_framer: frames FIFO payload words into IDLE/SOP/HDR/PAYLOAD/EOP
// packets for one 16-bit HSST TX lane.
//
// Ports:
//   clk                 : rising-edge clock for all logic
//   rst_n               : asynchronous active-low reset
//   link_ready          : lane is up, sampled only while idle
//   fifo_rd_data        : FIFO read data, valid one cycle after fifo_rd_en
//   fifo_rd_empty       : FIFO empty flag
//   fifo_rd_water_level : FIFO fill level in 16-bit words
//   fifo_rd_en          : FIFO read enable (combinational)
//   tx_data             : registered lane word
//   tx_charisk          : registered per-byte K flags for tx_data
//   pkt_done            : one-cycle pulse while the EOP word is on tx_data
//   err_underflow       : sticky, set when a read hits an empty FIFO
module hsst_tx_framer #(
  parameter int PKT_LEN  = 1024,
  parameter int IDLE_MIN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_ready,
  input  logic [15:0] fifo_rd_data,
  input  logic        fifo_rd_empty,
  input  logic [12:0] fifo_rd_water_level,
  output logic        fifo_rd_en,
  output logic [15:0] tx_data,
  output logic [1:0]  tx_charisk,
  output logic        pkt_done,
  output logic        err_underflow
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SOP     = 3'd1;
  localparam logic [2:0] ST_HDR     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_EOP     = 3'd4;

  localparam logic [15:0] W_IDLE = 16'h50BC;
  localparam logic [15:0] W_SOP  = 16'h00FB;
  localparam logic [15:0] W_EOP  = 16'h00FD;

  localparam logic [12:0] LEN13    = 13'(PKT_LEN);
  localparam logic [10:0] LAST_IDX = 11'(PKT_LEN - 1);
  localparam logic [7:0]  IDLE_THR = 8'(IDLE_MIN - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_idle_cnt;
  logic [10:0] r_wcnt;
  logic [15:0] r_seq;
  logic [15:0] r_tx_data;
  logic [1:0]  r_tx_k;
  logic        r_pkt_done;
  logic        r_err;

  logic [2:0]  w_nxt_state;
  logic        w_start;
  logic        w_last;
  logic        w_rd_en;
  logic [15:0] w_word;
  logic [1:0]  w_k;

  assign w_start = link_ready
                && (r_idle_cnt >= IDLE_THR)
                && (fifo_rd_water_level >= LEN13);

  assign w_last = (r_wcnt == LAST_IDX);

  // HDR issues the first read; the final PAYLOAD
  // cycle only consumes the last word.
  assign w_rd_en = (r_state == ST_HDR)
                || ((r_state == ST_PAYLOAD) && !w_last);

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_nxt_state = ST_SOP;
      end
      ST_SOP:  w_nxt_state = ST_HDR;
      ST_HDR:  w_nxt_state = ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (w_last) w_nxt_state = ST_EOP;
      end
      ST_EOP:  w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_word = W_IDLE;
    w_k    = 2'b01;
    case (r_state)
      ST_SOP: begin
        w_word = W_SOP;
        w_k    = 2'b01;
      end
      ST_HDR: begin
        w_word = r_seq;
        w_k    = 2'b00;
      end
      ST_PAYLOAD: begin
        w_word = fifo_rd_data;
        w_k    = 2'b00;
      end
      ST_EOP: begin
        w_word = W_EOP;
        w_k    = 2'b01;
      end
      default: begin
        w_word = W_IDLE;
        w_k    = 2'b01;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Counts only while staying idle, so it restarts
  // from zero on every new idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= 8'd0;
    end else if ((r_state == ST_IDLE)
              && (w_nxt_state == ST_IDLE)) begin
      if (r_idle_cnt != 8'hFF)
        r_idle_cnt <= r_idle_cnt + 8'd1;
    end else begin
      r_idle_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= 11'd0;
    end else if (r_state == ST_PAYLOAD) begin
      r_wcnt <= w_last ? 11'd0 : r_wcnt + 11'd1;
    end else begin
      r_wcnt <= 11'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= 16'd0;
    end else if (r_state == ST_EOP) begin
      r_seq <= r_seq + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data  <= W_IDLE;
      r_tx_k     <= 2'b01;
      r_pkt_done <= 1'b0;
    end else begin
      r_tx_data  <= w_word;
      r_tx_k     <= w_k;
      r_pkt_done <= (r_state == ST_EOP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_rd_en && fifo_rd_empty) begin
      r_err <= 1'b1;
    end
  end

  assign fifo_rd_en    = w_rd_en;
  assign tx_data       = r_tx_data;
  assign tx_charisk    = r_tx_k;
  assign pkt_done      = r_pkt_done;
  assign err_underflow = r_err;

endmodule
